// File: rtl/reset_release_monitor_if.sv
// ---------------------------------------------------------------------------
// reset_release_monitor_if
//   Groups the monitored-reset input, the clear strobe and the status outputs
//   of reset_release_monitor into one bundle.
//
//   Handshake: there is no valid/ready pair. MON_RST_N and CLR are level
//   inputs sampled on every rising CLK edge. Every status output is a
//   registered level or a one-cycle pulse that is valid right after that edge.
//
//   Signals
//     MON_RST_N     master -> slave  monitored reset, active-low, sync to CLK
//     CLR           master -> slave  synchronous clear of SHORT_ERR/ASSERT_COUNT
//     IN_RESET      slave -> master  1 while held in reset or settling
//     ASSERT_PULSE  slave -> master  one-cycle pulse on a new assertion
//     RELEASE_PULSE slave -> master  one-cycle pulse when release is declared
//     SHORT_ERR     slave -> master  sticky short-assertion flag
//     ASSERT_COUNT  slave -> master  saturating assertion event count
//     STATE_DBG     slave -> master  FSM state: 0=RUN, 1=ASSERTED, 2=SETTLE
// ---------------------------------------------------------------------------
interface reset_release_monitor_if #(
    parameter int CNTW = 8
);
    logic            MON_RST_N;
    logic            CLR;
    logic            IN_RESET;
    logic            ASSERT_PULSE;
    logic            RELEASE_PULSE;
    logic            SHORT_ERR;
    logic [CNTW-1:0] ASSERT_COUNT;
    logic [1:0]      STATE_DBG;

    modport master (
        output MON_RST_N,
        output CLR,
        input  IN_RESET,
        input  ASSERT_PULSE,
        input  RELEASE_PULSE,
        input  SHORT_ERR,
        input  ASSERT_COUNT,
        input  STATE_DBG
    );

    modport slave (
        input  MON_RST_N,
        input  CLR,
        output IN_RESET,
        output ASSERT_PULSE,
        output RELEASE_PULSE,
        output SHORT_ERR,
        output ASSERT_COUNT,
        output STATE_DBG
    );
endinterface

// File: rtl/reset_release_monitor.sv
// ---------------------------------------------------------------------------
// reset_release_monitor
//   Consumer-side watcher for a generated reset that is already synchronous
//   to CLK. Reports assertion (ASSERT_PULSE, counted in ASSERT_COUNT) and
//   release (RELEASE_PULSE) of the monitored reset. Release is declared only
//   after SETTLE consecutive deasserted samples. An assertion shorter than
//   MIN_ASSERT cycles sets the sticky SHORT_ERR.
//
//   Ports
//     CLK    clock, all logic on posedge
//     RST_N  asynchronous active-low reset of this block
//     bus    reset_release_monitor_if.slave (MON_RST_N, CLR in; status out)
// ---------------------------------------------------------------------------
module reset_release_monitor #(
    parameter int MIN_ASSERT = 2,
    parameter int SETTLE     = 4,
    parameter int CNTW       = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    reset_release_monitor_if.slave        bus
);
    localparam int LENW = $clog2(MIN_ASSERT + 1);
    localparam int SCW  = $clog2(SETTLE + 1);

    localparam logic [LENW-1:0] LEN_MAX   = LENW'(MIN_ASSERT);
    localparam logic [SCW-1:0]  SCNT_LAST = SCW'(SETTLE);
    localparam logic [CNTW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_ASSERTED = 2'd1,
        ST_SETTLE   = 2'd2
    } state_t;

    state_t          state_q,         state_d;
    logic [LENW-1:0] len_q,           len_d;
    logic [SCW-1:0]  scnt_q,          scnt_d;
    logic            in_reset_q,      in_reset_d;
    logic            assert_pulse_q,  assert_pulse_d;
    logic            release_pulse_q, release_pulse_d;
    logic            short_err_q,     short_err_d;
    logic [CNTW-1:0] assert_count_q,  assert_count_d;

    logic            short_set;
    logic            count_inc;
    logic [SCW-1:0]  scnt_inc;

    assign scnt_inc = scnt_q + SCW'(1);

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        scnt_d          = scnt_q;
        in_reset_d      = in_reset_q;
        assert_pulse_d  = 1'b0;
        release_pulse_d = 1'b0;
        short_set       = 1'b0;
        count_inc       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!bus.MON_RST_N) begin
                    state_d        = ST_ASSERTED;
                    in_reset_d     = 1'b1;
                    assert_pulse_d = 1'b1;
                    count_inc      = 1'b1;
                    len_d          = LENW'(1);
                end
            end
            ST_ASSERTED: begin
                if (!bus.MON_RST_N) begin
                    len_d = (len_q == LEN_MAX) ? len_q : len_q + LENW'(1);
                end else begin
                    short_set = (len_q < LEN_MAX);
                    if (SETTLE == 1) begin
                        state_d         = ST_RUN;
                        release_pulse_d = 1'b1;
                        in_reset_d      = 1'b0;
                    end else begin
                        state_d = ST_SETTLE;
                        scnt_d  = SCW'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (bus.MON_RST_N) begin
                    if (scnt_inc == SCNT_LAST) begin
                        state_d         = ST_RUN;
                        release_pulse_d = 1'b1;
                        in_reset_d      = 1'b0;
                        scnt_d          = '0;
                    end else begin
                        scnt_d = scnt_inc;
                    end
                end else begin
                    // Glitch while settling: back to ASSERTED without a new
                    // event; the re-entry length is measured afresh.
                    state_d = ST_ASSERTED;
                    len_d   = LENW'(1);
                    scnt_d  = '0;
                end
            end
            default: begin
                state_d    = ST_ASSERTED;
                in_reset_d = 1'b1;
            end
        endcase

        // A set event in the same cycle as CLR wins over the clear.
        if (short_set) begin
            short_err_d = 1'b1;
        end else if (bus.CLR) begin
            short_err_d = 1'b0;
        end else begin
            short_err_d = short_err_q;
        end

        if (count_inc) begin
            if (bus.CLR) begin
                assert_count_d = CNTW'(1);
            end else begin
                assert_count_d = (assert_count_q == CNT_MAX) ? assert_count_q
                                                             : assert_count_q + CNTW'(1);
            end
        end else if (bus.CLR) begin
            assert_count_d = '0;
        end else begin
            assert_count_d = assert_count_q;
        end
    end

    // Length counter preset to MIN_ASSERT so leaving the power-up reset never
    // counts as a short assertion.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= ST_ASSERTED;
            len_q           <= LEN_MAX;
            scnt_q          <= '0;
            in_reset_q      <= 1'b1;
            assert_pulse_q  <= 1'b0;
            release_pulse_q <= 1'b0;
            short_err_q     <= 1'b0;
            assert_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            scnt_q          <= scnt_d;
            in_reset_q      <= in_reset_d;
            assert_pulse_q  <= assert_pulse_d;
            release_pulse_q <= release_pulse_d;
            short_err_q     <= short_err_d;
            assert_count_q  <= assert_count_d;
        end
    end

    assign bus.IN_RESET      = in_reset_q;
    assign bus.ASSERT_PULSE  = assert_pulse_q;
    assign bus.RELEASE_PULSE = release_pulse_q;
    assign bus.SHORT_ERR     = short_err_q;
    assign bus.ASSERT_COUNT  = assert_count_q;
    assign bus.STATE_DBG     = state_q;
endmodule

// File: tb/tb_reset_release_monitor.sv
module tb_reset_release_monitor;
  localparam int MIN_ASSERT = 2;
  localparam int SETTLE     = 4;
  localparam int CNTW       = 4;
  localparam int CNT_MAX    = (1 << CNTW) - 1;
  localparam int W          = 2 + 4 + CNTW;

  // State codes as published on STATE_DBG
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_ASSERTED = 2'd1;
  localparam logic [1:0] S_SETTLE   = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reset_release_monitor_if #(.CNTW(CNTW)) mon_if ();

  reset_release_monitor #(
    .MIN_ASSERT(MIN_ASSERT),
    .SETTLE    (SETTLE),
    .CNTW      (CNTW)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (mon_if)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // Run-length view: how many lows/highs in a row, and whether the consumer
  // is currently considered to be in reset.
  bit m_in_reset;
  int m_low_run;
  int m_high_run;
  bit m_short;
  int m_count;
  bit m_ap;
  bit m_rp;

  logic [W-1:0] exp_q[$];

  function automatic logic [1:0] model_state();
    if (!m_in_reset) return S_RUN;
    if (m_high_run == 0) return S_ASSERTED;
    return S_SETTLE;
  endfunction

  task automatic model_reset();
    m_in_reset = 1;
    m_low_run  = MIN_ASSERT;
    m_high_run = 0;
    m_short    = 0;
    m_count    = 0;
    m_ap       = 0;
    m_rp       = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic mon, input logic clr);
    bit short_set;
    bit new_assert;
    short_set  = 0;
    new_assert = 0;
    m_ap = 0;
    m_rp = 0;
    if (!mon) begin
      if (!m_in_reset) begin
        new_assert = 1;
        m_ap       = 1;
        m_in_reset = 1;
      end
      if (m_low_run < 1000) m_low_run++;
      m_high_run = 0;
    end else begin
      if (m_in_reset) begin
        if (m_high_run == 0 && m_low_run < MIN_ASSERT) short_set = 1;
        m_high_run++;
        if (m_high_run == SETTLE) begin
          m_rp       = 1;
          m_in_reset = 0;
        end
      end
      m_low_run = 0;
    end
    if (short_set) m_short = 1;
    else if (clr) m_short = 0;
    if (new_assert) m_count = clr ? 1 : ((m_count == CNT_MAX) ? CNT_MAX : m_count + 1);
    else if (clr) m_count = 0;
    exp_q.push_back({model_state(), m_in_reset, m_ap, m_rp, m_short, CNTW'(m_count)});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check({tag, ".state"},  16'(mon_if.STATE_DBG),     16'(e[W-1 -: 2]));
    check({tag, ".in_rst"}, 16'(mon_if.IN_RESET),      16'(e[CNTW+3]));
    check({tag, ".apulse"}, 16'(mon_if.ASSERT_PULSE),  16'(e[CNTW+2]));
    check({tag, ".rpulse"}, 16'(mon_if.RELEASE_PULSE), 16'(e[CNTW+1]));
    check({tag, ".short"},  16'(mon_if.SHORT_ERR),     16'(e[CNTW]));
    check({tag, ".count"},  16'(mon_if.ASSERT_COUNT),  16'(e[CNTW-1:0]));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".state"},  16'(mon_if.STATE_DBG),     16'(S_ASSERTED));
    check({tag, ".in_rst"}, 16'(mon_if.IN_RESET),      16'd1);
    check({tag, ".apulse"}, 16'(mon_if.ASSERT_PULSE),  16'd0);
    check({tag, ".rpulse"}, 16'(mon_if.RELEASE_PULSE), 16'd0);
    check({tag, ".short"},  16'(mon_if.SHORT_ERR),     16'd0);
    check({tag, ".count"},  16'(mon_if.ASSERT_COUNT),  16'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic mon, input logic clr, input string tag);
    mon_if.MON_RST_N = mon;
    mon_if.CLR       = clr;
    @(posedge clk);
    model_edge(mon, clr);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input logic mon, input int n, input string tag);
    for (int i = 0; i < n; i++) step(mon, 1'b0, tag);
  endtask

  // Async reset pulse placed mid-cycle, well away from the clock edges.
  task automatic pulse_rst(input string tag);
    #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_reset(tag);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic mon_r;
    int   run_left;

    mon_if.MON_RST_N = 1'b1;
    mon_if.CLR       = 1'b0;
    model_reset();
    #12;
    check_reset("t1_reset");
    rst_n = 1'b1;

    // 1. power-up release
    steps(1'b1, 3, "t1_settle");
    check("t1_still_in_reset", 16'(mon_if.IN_RESET), 16'd1);
    step(1'b1, 1'b0, "t1_release");
    check("t1_rpulse", 16'(mon_if.RELEASE_PULSE), 16'd1);
    step(1'b1, 1'b0, "t1_run");
    check("t1_in_reset_low", 16'(mon_if.IN_RESET), 16'd0);

    // 2. normal 3-cycle assertion
    step(1'b0, 1'b0, "t2_first_low");
    check("t2_apulse", 16'(mon_if.ASSERT_PULSE), 16'd1);
    steps(1'b0, 2, "t2_low");
    steps(1'b1, 4, "t2_high");
    check("t2_rpulse", 16'(mon_if.RELEASE_PULSE), 16'd1);
    check("t2_count", 16'(mon_if.ASSERT_COUNT), 16'd1);
    check("t2_short", 16'(mon_if.SHORT_ERR), 16'd0);

    // 3. short assertion, then clear
    step(1'b0, 1'b0, "t3_low");
    steps(1'b1, 4, "t3_high");
    check("t3_short", 16'(mon_if.SHORT_ERR), 16'd1);
    check("t3_count", 16'(mon_if.ASSERT_COUNT), 16'd2);
    steps(1'b1, 2, "t3_sticky");
    step(1'b1, 1'b1, "t3_clr");
    check("t3_short_clr", 16'(mon_if.SHORT_ERR), 16'd0);
    check("t3_count_clr", 16'(mon_if.ASSERT_COUNT), 16'd0);

    // 4. glitch during settle
    steps(1'b0, 3, "t4_low");
    steps(1'b1, 2, "t4_high");
    step(1'b0, 1'b0, "t4_glitch");
    check("t4_no_apulse", 16'(mon_if.ASSERT_PULSE), 16'd0);
    check("t4_held", 16'(mon_if.IN_RESET), 16'd1);
    steps(1'b1, 4, "t4_resettle");
    check("t4_rpulse", 16'(mon_if.RELEASE_PULSE), 16'd1);
    check("t4_count", 16'(mon_if.ASSERT_COUNT), 16'd1);
    check("t4_short", 16'(mon_if.SHORT_ERR), 16'd1);

    // 5. saturation, then CLR together with a new assertion
    for (int k = 0; k < 20; k++) begin
      steps(1'b0, 2, "t5_low");
      steps(1'b1, 4, "t5_high");
    end
    check("t5_sat", 16'(mon_if.ASSERT_COUNT), 16'(CNT_MAX));
    step(1'b0, 1'b1, "t5_clr_assert");
    check("t5_clr_wins_lost", 16'(mon_if.ASSERT_COUNT), 16'd1);
    steps(1'b0, 1, "t5_low2");
    steps(1'b1, 4, "t5_rel");

    // 6. RST_N while settling (scnt=2)
    steps(1'b0, 2, "t6_low");
    steps(1'b1, 2, "t6_settle");
    check("t6_in_settle", 16'(mon_if.STATE_DBG), 16'(S_SETTLE));
    pulse_rst("t6_rst");
    steps(1'b1, 4, "t6_release");
    check("t6_rpulse", 16'(mon_if.RELEASE_PULSE), 16'd1);
    check("t6_short", 16'(mon_if.SHORT_ERR), 16'd0);

    // Random phase: run-length stimulus with sporadic CLR and RST_N pulses
    mon_r    = 1'b1;
    run_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (run_left == 0) begin
        mon_r    = ~mon_r;
        run_left = (mon_r) ? $urandom_range(1, 7) : $urandom_range(1, 4);
      end
      run_left--;
      step(mon_r, ($urandom_range(0, 11) == 0), "rand");
      if ($urandom_range(0, 199) == 0) pulse_rst("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
